// File: rtl/instr_mem_loader_pkg.sv
// Shared types and constants for the instruction memory loader.
// Imported by the loader top and its byte packer.
package instr_loader_pkg;

  localparam int unsigned INSTR_W        = 24;
  localparam int unsigned BYTES_PER_WORD = INSTR_W / 8;
  localparam int unsigned LEN_BYTES      = 2;

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    DATA,
    CHK,
    DONE,
    ERR
  } state_e;

endpackage

// File: rtl/instr_mem_loader_if.sv
// Byte-stream and memory-write bundle of the loader.
// master = loader side, slave = host link / memory side.
interface instr_mem_loader_if #(
  parameter int unsigned N  = 24,
  parameter int unsigned AW = 10
);

  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [N-1:0]  mem_wdata;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/instr_mem_loader_byte_packer.sv
// Shifts bytes MSB-first into a word; word_full marks
// the push that completes it (word is valid that cycle).
module byte_packer
  import instr_loader_pkg::*;
#(
  parameter int unsigned BPW = BYTES_PER_WORD,
  parameter int unsigned N   = 8 * BPW
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         push,
  input  logic [7:0]   din,
  output logic [N-1:0] word,
  output logic         word_full
);

  localparam int unsigned CW = $clog2(BPW + 1);

  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-9:0]   sh_q, sh_d;

  always_comb begin
    word      = {sh_q, din};
    word_full = push && (cnt_q == CW'(BPW - 1));
    sh_d      = sh_q;
    cnt_d     = cnt_q;
    if (clr) begin
      sh_d  = '0;
      cnt_d = '0;
    end else if (push) begin
      sh_d  = word[N-9:0];
      cnt_d = word_full ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Loads a length-prefixed, XOR-checked byte image into
// the instruction memory, holding the CPU while it runs.
module instr_mem_loader
  import instr_loader_pkg::*;
#(
  parameter int unsigned N     = INSTR_W,
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  instr_mem_loader_if.master bus,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          cpu_hold,
  output logic [AW:0]   word_count
);

  localparam int unsigned LW = 8 * LEN_BYTES;

  state_e        state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [7:0]    chk_q, chk_d;
  logic [AW:0]   wc_q, wc_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [N-1:0]  wdata_q, wdata_d;
  logic          rdy_q, rdy_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          hold_q, hold_d;

  logic          acc, take_start, push;
  logic          word_full;
  logic [N-1:0]  word;
  logic [LW-1:0] len_full;

  assign acc        = bus.rx_valid && rdy_q;
  assign take_start = start &&
    (state_q inside {IDLE, DONE, ERR});
  assign push       = acc && (state_q == DATA);
  assign len_full   = {len_q[LW-1:8], bus.rx_data};

  byte_packer #(.BPW(N / 8), .N(N)) u_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (take_start),
    .push     (push),
    .din      (bus.rx_data),
    .word     (word),
    .word_full(word_full)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    chk_d   = chk_q;
    wc_d    = wc_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (take_start) begin
      state_d = HDR0;
      chk_d   = '0;
      wc_d    = '0;
    end else begin
      unique case (state_q)
        HDR0: if (acc) begin
          len_d[LW-1:8] = bus.rx_data;
          state_d       = HDR1;
        end
        HDR1: if (acc) begin
          len_d = len_full;
          if (len_full == '0 || len_full > LW'(DEPTH))
            state_d = ERR;
          else
            state_d = DATA;
        end
        DATA: if (acc) begin
          chk_d = chk_q ^ bus.rx_data;
          if (word_full) begin
            we_d    = 1'b1;
            addr_d  = wc_q[AW-1:0];
            wdata_d = word;
            wc_d    = wc_q + 1'b1;
            if (LW'(wc_q) + LW'(1) == len_q)
              state_d = CHK;
          end
        end
        CHK: if (acc) begin
          state_d = (bus.rx_data == chk_q) ? DONE : ERR;
        end
        default: ;
      endcase
    end
    // Status flags are registered copies of the next state
    rdy_d  = state_d inside {HDR0, HDR1, DATA, CHK};
    busy_d = rdy_d;
    hold_d = rdy_d || (state_d == ERR);
    done_d = (state_d == DONE);
    err_d  = (state_d == ERR);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      chk_q   <= '0;
      wc_q    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      chk_q   <= chk_d;
      wc_q    <= wc_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
    end
  end

  assign bus.rx_ready  = rdy_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign cpu_hold      = hold_q;
  assign word_count    = wc_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader with a write scoreboard.
// Expected writes are queued as bytes are sent, popped on mem_we.
module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, err, cpu_hold;
  logic [10:0] word_count;

  int          checks = 0;
  int          errors = 0;
  int          wr_cnt = 0;
  int          last_addr = -1;
  logic [33:0] exp_q[$];
  logic [7:0]  pay[$];

  instr_mem_loader_if #(.N(24), .AW(10)) bus ();

  instr_mem_loader #(.N(24), .DEPTH(1024), .AW(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .cpu_hold  (cpu_hold),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every mem_we cycle must match the oldest expected write
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wr_cnt++;
      last_addr = int'(bus.mem_addr);
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(bus.mem_addr), 32'hFFFF_FFFF);
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(bus.mem_addr), 32'(e[33:24]));
        check("wr_data", 32'(bus.mem_wdata), 32'(e[23:0]));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit exp_we,
                           input int gap);
    int n;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    n = 0;
    while (bus.rx_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) begin
      check("rx_ready_timeout", 32'd0, 32'd1);
      bus.rx_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    check("mem_we_timing", 32'(bus.mem_we), 32'(exp_we));
  endtask

  task automatic pulse_start(input bit collide);
    @(negedge clk);
    start        = 1'b1;
    bus.rx_valid = collide;
    bus.rx_data  = 8'h55;
    @(negedge clk);
    start        = 1'b0;
    bus.rx_valid = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    check("rdy_after_start", 32'(bus.rx_ready), 32'd1);
  endtask

  task automatic run_load(input logic [15:0] len, input bit gapped,
                          input bit bad_chk, input bit collide);
    logic [7:0]  x;
    logic [23:0] w;
    int          k, a, wr0;
    bit          full;
    x = '0; w = '0; k = 0; a = 0;
    wr0 = wr_cnt;
    pulse_start(collide);
    send_byte(len[15:8], 1'b0, gapped ? $urandom_range(0, 3) : 0);
    send_byte(len[7:0], 1'b0, gapped ? $urandom_range(0, 3) : 0);
    foreach (pay[i]) begin
      x = x ^ pay[i];
      w = {w[15:0], pay[i]};
      k++;
      full = (k == 3);
      if (full) begin
        exp_q.push_back({a[9:0], w});
        a++;
        k = 0;
      end
      send_byte(pay[i], full, gapped ? $urandom_range(0, 3) : 0);
    end
    check("hold_during_load", 32'(cpu_hold), 32'd1);
    check("busy_during_load", 32'(busy), 32'd1);
    send_byte(bad_chk ? 8'h00 : x, 1'b0, gapped ? $urandom_range(0, 3) : 0);
    check("done", 32'(done), bad_chk ? 32'd0 : 32'd1);
    check("err", 32'(err), bad_chk ? 32'd1 : 32'd0);
    check("cpu_hold", 32'(cpu_hold), bad_chk ? 32'd1 : 32'd0);
    check("busy_end", 32'(busy), 32'd0);
    check("word_count", 32'(word_count), 32'(len));
    check("writes", 32'(wr_cnt - wr0), 32'(len));
    check("sb_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rdy"}, 32'(bus.rx_ready), 32'd0);
    check({tag, "_we"}, 32'(bus.mem_we), 32'd0);
    check({tag, "_addr"}, 32'(bus.mem_addr), 32'd0);
    check({tag, "_wdata"}, 32'(bus.mem_wdata), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_hold"}, 32'(cpu_hold), 32'd0);
    check({tag, "_wc"}, 32'(word_count), 32'd0);
  endtask

  task automatic set_pay6();
    pay = '{8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF};
  endtask

  initial begin
    int wr0;
    bus.rx_data  = '0;
    bus.rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Normal load; a byte offered with start in IDLE must be ignored
    set_pay6();
    run_load(16'h0002, 1'b0, 1'b0, 1'b1);

    // Bad checksum: writes still happen, err sticks, CPU held
    run_load(16'h0002, 1'b0, 1'b1, 1'b0);

    // Zero length
    wr0 = wr_cnt;
    pulse_start(1'b0);
    send_byte(8'h00, 1'b0, 0);
    send_byte(8'h00, 1'b0, 0);
    check("len0_err", 32'(err), 32'd1);
    check("len0_hold", 32'(cpu_hold), 32'd1);
    check("len0_rdy", 32'(bus.rx_ready), 32'd0);
    repeat (3) @(negedge clk);
    check("len0_no_write", 32'(wr_cnt - wr0), 32'd0);

    // Length 1025 exceeds depth
    pulse_start(1'b0);
    send_byte(8'h04, 1'b0, 0);
    send_byte(8'h01, 1'b0, 0);
    check("len1025_err", 32'(err), 32'd1);
    check("len1025_done", 32'(done), 32'd0);
    run_load(16'h0002, 1'b0, 1'b0, 1'b0);

    // Gapped stream
    run_load(16'h0002, 1'b1, 1'b0, 1'b0);

    // Reset after four payload bytes
    pulse_start(1'b0);
    send_byte(8'h00, 1'b0, 0);
    send_byte(8'h02, 1'b0, 0);
    exp_q.push_back({10'd0, 24'h123456});
    send_byte(8'h12, 1'b0, 0);
    send_byte(8'h34, 1'b0, 0);
    send_byte(8'h56, 1'b1, 0);
    send_byte(8'hAB, 1'b0, 0);
    wr0 = wr_cnt;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("midrst_no_write", 32'(wr_cnt - wr0), 32'd0);
    check("midrst_sb", 32'(exp_q.size()), 32'd0);
    run_load(16'h0002, 1'b0, 1'b0, 1'b0);

    // Full depth
    pay.delete();
    for (int i = 0; i < 3072; i++) pay.push_back(8'((i * 37 + 11) & 255));
    run_load(16'h0400, 1'b0, 1'b0, 1'b0);
    check("last_addr", 32'(last_addr), 32'd1023);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
